// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg
// Shared types and defaults for the single-port video RAM arbiter.
//   owner_e : which requester issued a RAM access
//   tag_t   : read-return tag carried alongside the RAM read latency
//   AW_DEF / DW_DEF : default address/data widths of the RAM window
package vram_arb_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PPU  = 2'd2
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_NONE};

endpackage

// File: rtl/arb_wait_cnt.sv
// arb_wait_cnt
// Saturating starvation counter for the CPU side of the arbiter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   inc        : request refused this cycle
//   clr        : request granted or withdrawn (wins over inc)
//   at_max     : counter has reached MAX; the CPU must be served now
module arb_wait_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one synchronous single-port video RAM between the 6502 data bus
// and the character PPU fetch path. The PPU has priority during active
// display; the CPU is guaranteed service after CPU_MAX_WAIT refusals.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   de                              : display enable (1 = active area)
//   cpu_req/we/addr/wdata, cpu_gnt  : CPU request side (gnt is combinational)
//   cpu_rdata, cpu_rvalid           : CPU read return
//   ppu_req/addr, ppu_gnt           : PPU fetch side (read only)
//   ppu_rdata, ppu_rvalid           : PPU read return
//   mem_en/we/addr/wdata, mem_rdata : registered RAM command, RAM read data
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ppu_req,
    input  logic [AW-1:0] ppu_addr,
    output logic          ppu_gnt,
    output logic [DW-1:0] ppu_rdata,
    output logic          ppu_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic cpu_force;
    tag_t s1_next;
    tag_t s1;
    tag_t s2;

    // Refused while requesting -> count; granted or withdrawn -> clear.
    arb_wait_cnt #(.MAX(CPU_MAX_WAIT)) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (cpu_req && !cpu_gnt),
        .clr    (!cpu_req || cpu_gnt),
        .at_max (cpu_force)
    );

    assign cpu_gnt = cpu_req && (cpu_force || !de || !ppu_req);
    assign ppu_gnt = ppu_req && !cpu_gnt;

    // Writes occupy the pipeline slot but never return data.
    always_comb begin
        s1_next = TAG_IDLE;
        if (cpu_gnt) begin
            s1_next.valid = !cpu_we;
            s1_next.owner = OWN_CPU;
        end else if (ppu_gnt) begin
            s1_next.valid = 1'b1;
            s1_next.owner = OWN_PPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1        <= TAG_IDLE;
            s2        <= TAG_IDLE;
        end else begin
            mem_en <= cpu_gnt || ppu_gnt;
            mem_we <= cpu_gnt && cpu_we;
            if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (ppu_gnt) begin
                mem_addr  <= ppu_addr;
                mem_wdata <= '0;
            end
            s1 <= s1_next;
            // s2 lines up with mem_rdata from the synchronous RAM.
            s2 <= s1;
        end
    end

    assign cpu_rvalid = s2.valid && (s2.owner == OWN_CPU);
    assign ppu_rvalid = s2.valid && (s2.owner == OWN_PPU);
    assign cpu_rdata  = mem_rdata;
    assign ppu_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int MAXW = 4;

    logic          clk;
    logic          rst_n;
    logic          de;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          ppu_req;
    logic [AW-1:0] ppu_addr;
    logic          ppu_gnt;
    logic [DW-1:0] ppu_rdata;
    logic          ppu_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    vram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de         (de),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ppu_req    (ppu_req),
        .ppu_addr   (ppu_addr),
        .ppu_gnt    (ppu_gnt),
        .ppu_rdata  (ppu_rdata),
        .ppu_rvalid (ppu_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        v = 8'(a) ^ 8'h5A;
        if (a == 16'h0010) v = 8'hA5;
        return v;
    endfunction

    // Synchronous RAM model
    logic [7:0] ram [0:32767];
    logic preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 32768; i++) ram[i] <= init_val(i);
            preloaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard
    typedef struct {
        owner_e     owner;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    logic [7:0] shadow [0:32767];

    initial begin : monitor
        exp_t e;
        for (int i = 0; i < 32768; i++) shadow[i] = init_val(i);
        forever begin
            @(negedge clk);
            #1;
            if (cpu_rvalid || ppu_rvalid) begin
                if (cpu_rvalid && ppu_rvalid)
                    chk("rvalid_both", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", {cpu_rvalid, ppu_rvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_owner", cpu_rvalid ? OWN_CPU : OWN_PPU, e.owner);
                    chk("ret_data", cpu_rvalid ? cpu_rdata : ppu_rdata, e.data);
                end
            end
            #1;
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (cpu_req && cpu_gnt) begin
                    if (cpu_we) shadow[cpu_addr] = cpu_wdata;
                    else exp_q.push_back('{OWN_CPU, shadow[cpu_addr]});
                end
                if (ppu_req && ppu_gnt)
                    exp_q.push_back('{OWN_PPU, shadow[ppu_addr]});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic c_req, input logic c_we, input logic [14:0] c_addr,
                         input logic [7:0] c_wd, input logic p_req, input logic [14:0] p_addr,
                         input logic de_i, output logic cg, output logic pg);
        @(negedge clk);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        ppu_req   = p_req;
        ppu_addr  = p_addr;
        de        = de_i;
        #3;
        cg = cpu_gnt;
        pg = ppu_gnt;
    endtask

    task automatic idle(output logic cg, output logic pg);
        drive(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 15'h0, 1'b1, cg, pg);
    endtask

    initial begin : stim
        logic cg, pg;
        logic c_pend, p_pend, c_we_r;
        logic [14:0] c_addr_r, p_addr_r;
        logic [7:0]  c_wd_r;
        int seen, both_cnt, run, max_run;
        logic exp_c;

        rst_n = 1'b0;
        de = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ppu_req = 1'b0; ppu_addr = '0;

        // Reset held with random requests
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 15'($urandom), 8'($urandom),
                  1'($urandom), 15'($urandom), 1'($urandom), cg, pg);
            chk("rst_mem_cmd", {mem_en, mem_we, 8'(mem_addr), mem_wdata}, 32'd0);
            chk("rst_mem_addr_hi", 32'(mem_addr), 32'd0);
            chk("rst_rvalid", {cpu_rvalid, ppu_rvalid}, 32'd0);
        end
        idle(cg, pg);
        @(negedge clk);
        rst_n = 1'b1;

        // First CPU read after reset: 2-edge latency
        drive(1'b1, 1'b0, 15'h0010, 8'h00, 1'b0, 15'h0, 1'b1, cg, pg);
        chk("first_cpu_gnt", {cg, pg}, 32'b10);
        idle(cg, pg);
        chk("first_lat_early", cpu_rvalid, 32'd0);
        idle(cg, pg);
        chk("first_lat_rvalid", cpu_rvalid, 32'd1);
        chk("first_rdata", cpu_rdata, 32'hA5);

        // Blanking contention: CPU first, PPU next, returns in order
        drive(1'b1, 1'b0, 15'h0020, 8'h00, 1'b1, 15'h0030, 1'b0, cg, pg);
        chk("blank_c1", {cg, pg}, 32'b10);
        drive(1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 15'h0030, 1'b0, cg, pg);
        chk("blank_c2", {cg, pg}, 32'b01);
        idle(cg, pg);
        chk("blank_ret1", {cpu_rvalid, ppu_rvalid}, 32'b10);
        chk("blank_ret1_data", cpu_rdata, 32'(8'h20 ^ 8'h5A));
        idle(cg, pg);
        chk("blank_ret2", {cpu_rvalid, ppu_rvalid}, 32'b01);
        chk("blank_ret2_data", ppu_rdata, 32'(8'h30 ^ 8'h5A));
        idle(cg, pg);

        // Starvation bound: 4 PPU grants, CPU, PPU resumes
        c_pend = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(c_pend, 1'b0, 15'h0100, 8'h00, 1'b1, 15'(16'h0200 + i), 1'b1, cg, pg);
            if (cg) c_pend = 1'b0;
            exp_c = (i == 4);
            chk($sformatf("starve_c%0d", i), {cg, pg}, {30'd0, exp_c, !exp_c});
        end

        // de falls mid-wait: CPU wins the same cycle
        drive(1'b1, 1'b0, 15'h0101, 8'h00, 1'b1, 15'h0300, 1'b1, cg, pg);
        chk("defall_c0", {cg, pg}, 32'b01);
        drive(1'b1, 1'b0, 15'h0101, 8'h00, 1'b1, 15'h0301, 1'b1, cg, pg);
        chk("defall_c1", {cg, pg}, 32'b01);
        drive(1'b1, 1'b0, 15'h0101, 8'h00, 1'b1, 15'h0302, 1'b0, cg, pg);
        chk("defall_c2", {cg, pg}, 32'b10);

        // Dropped request clears the wait count
        drive(1'b1, 1'b0, 15'h0102, 8'h00, 1'b1, 15'h0310, 1'b1, cg, pg);
        chk("drop_c0", {cg, pg}, 32'b01);
        drive(1'b0, 1'b0, 15'h0102, 8'h00, 1'b1, 15'h0311, 1'b1, cg, pg);
        chk("drop_c1", {cg, pg}, 32'b01);
        c_pend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(c_pend, 1'b0, 15'h0103, 8'h00, 1'b1, 15'(16'h0320 + i), 1'b1, cg, pg);
            if (cg) c_pend = 1'b0;
            exp_c = (i == 4);
            chk($sformatf("drop_refill_c%0d", i), {cg, pg}, {30'd0, exp_c, !exp_c});
        end
        idle(cg, pg); idle(cg, pg); idle(cg, pg);

        // Write then read from the PPU next cycle
        drive(1'b1, 1'b1, 15'h7FFF, 8'h3C, 1'b0, 15'h0, 1'b1, cg, pg);
        chk("wr_gnt", {cg, pg}, 32'b10);
        drive(1'b0, 1'b0, 15'h0, 8'h00, 1'b1, 15'h7FFF, 1'b1, cg, pg);
        chk("rd_after_wr_gnt", {cg, pg}, 32'b01);
        idle(cg, pg);
        chk("wr_no_rvalid", {cpu_rvalid, ppu_rvalid}, 32'b00);
        idle(cg, pg);
        chk("rd_after_wr_rvalid", {cpu_rvalid, ppu_rvalid}, 32'b01);
        chk("rd_after_wr_data", ppu_rdata, 32'h3C);
        idle(cg, pg);

        // Reset mid-flight
        drive(1'b0, 1'b0, 15'h0, 8'h00, 1'b1, 15'h0444, 1'b1, cg, pg);
        chk("mid_rst_gnt", {cg, pg}, 32'b01);
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0; ppu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #3;
            if (cpu_rvalid || ppu_rvalid) seen++;
        end
        chk("mid_rst_mem_en", {mem_en, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(cg, pg);
            if (cpu_rvalid || ppu_rvalid) seen++;
        end
        chk("mid_rst_no_rvalid", seen, 32'd0);

        // Random soak
        c_pend = 1'b0; p_pend = 1'b0; c_we_r = 1'b0;
        c_addr_r = '0; p_addr_r = '0; c_wd_r = '0;
        both_cnt = 0; run = 0; max_run = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!c_pend && ($urandom_range(0, 2) == 0)) begin
                c_pend = 1'b1; c_we_r = 1'($urandom);
                c_addr_r = 15'($urandom); c_wd_r = 8'($urandom);
            end
            if (!p_pend && ($urandom_range(0, 3) != 0)) begin
                p_pend = 1'b1; p_addr_r = 15'($urandom);
            end
            drive(c_pend, c_we_r, c_addr_r, c_wd_r, p_pend, p_addr_r,
                  $urandom_range(0, 3) != 0, cg, pg);
            if (cg && pg) both_cnt++;
            if (c_pend && !cg) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (cg) c_pend = 1'b0;
            if (pg) p_pend = 1'b0;
        end
        for (int i = 0; i < 4; i++) idle(cg, pg);
        chk("soak_gnt_exclusive", both_cnt, 32'd0);
        chk("soak_max_wait_le_max", max_run <= MAXW, 32'd1);
        chk("soak_all_returned", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter sharing one synchronous 8-bit RAM port between the 6502 data bus and the character PPU fetch path. Replaces the dual-port RAM arrangement. The CPU stalls through a grant/RDY handshake, and the PPU is served with priority during active display. A bounded-wait counter guarantees CPU progress, and a two-stage tag pipeline routes read data back to the requester that issued it.

## Interface
- AW, 15, address width (32 KiB RAM window)
- DW, 8, data width
- CPU_MAX_WAIT, 4, max consecutive cycles a pending CPU request may be refused; range 1..15
- clk  in  1  system/pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- de  in  1  display-enable from display timing; high = active area
- cpu_req  in  1  CPU access request; held with cpu_addr/cpu_we/cpu_wdata stable until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  combinational; request accepted at this edge (drives 6502 RDY via requester logic)
- cpu_rdata  out  DW  read data, valid when cpu_rvalid
- cpu_rvalid  out  1  one-cycle pulse per accepted CPU read
- ppu_req  in  1  PPU fetch request (read only), held until granted
- ppu_addr  in  AW  PPU fetch address
- ppu_gnt  out  1  combinational; fetch accepted at this edge
- ppu_rdata  out  DW  fetch data, valid when ppu_rvalid
- ppu_rvalid  out  1  one-cycle pulse per accepted PPU fetch
- mem_en  out  1  registered RAM enable
- mem_we  out  1  registered RAM write enable
- mem_addr  out  AW  registered RAM address
- mem_wdata  out  DW  registered RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en (synchronous read)

## Operation
- At most one grant per cycle; cpu_gnt and ppu_gnt are never both high.
- Priority rule, evaluated each cycle:
  - cpu_force = (wait_cnt == CPU_MAX_WAIT).
  - If cpu_req && (cpu_force || !de || !ppu_req): grant CPU.
  - Else if ppu_req: grant PPU.
  - Else: no grant.
- wait_cnt (4-bit):
  - Increments when cpu_req && !cpu_gnt, saturating at CPU_MAX_WAIT.
  - Clears on cpu_gnt, and when cpu_req is low.
- Accepted access (req && gnt at edge E): mem_en=1 and mem_addr/mem_we/mem_wdata are loaded at E. PPU accesses always use mem_we=0 and mem_wdata=0.
- Tag pipeline:
  - Stage 1 holds {valid, owner} for the read issued at E.
  - Stage 2 holds it one edge later, aligned with mem_rdata.
  - Writes enter the pipeline with valid=0 and produce no rvalid.
- Return path:
  - cpu_rvalid = s2_valid && owner==CPU.
  - ppu_rvalid = s2_valid && owner==PPU.
  - cpu_rdata and ppu_rdata both carry mem_rdata unconditionally; consumers qualify with rvalid.
- With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.

## Timing
- Reset (async assert, sync release): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait_cnt=0, both pipeline stages invalid, cpu_rvalid=0, ppu_rvalid=0. The gnt outputs follow the priority rule combinationally.
- Read latency: request accepted at edge E → mem_en high in cycle E..E+1 → rvalid high in cycle E+1..E+2, i.e. exactly 2 edges.
- Throughput: one access per cycle sustained. Back-to-back grants to alternating owners return in issue order, one rvalid per cycle.
- Write: RAM is written at edge E+1. A read of the same address granted at E+1 returns the new data.
- Simultaneous cpu_req and ppu_req with de=1 and wait_cnt<CPU_MAX_WAIT: PPU wins.
- Worst-case CPU wait during active display: CPU_MAX_WAIT refused cycles, then a grant on the next cycle.
- de falls mid-wait: CPU wins the same cycle. wait_cnt clears on that grant.
- Requester drops req without a grant: no access is issued, and wait_cnt clears.
- Reset asserted mid-flight: in-flight reads are discarded, and no rvalid is produced after reset.

## Structure
- Package vram_arb_pkg:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_CPU, OWN_PPU}.
  - Typedef for the pipeline tag struct {valid, owner}.
  - Default AW and DW constants.
- One sub-module, arb_wait_cnt: saturating starvation counter with parameter MAX, inputs inc/clr, output at_max.
- Top module: priority logic, registered memory command, two-stage tag pipeline.

## Test plan
- Reset: hold rst_n=0 with random requests → all mem_* outputs 0 and both rvalid 0. Release; CPU read of 0x0010 (RAM preloaded 0xA5) → cpu_rvalid high 2 edges after grant, cpu_rdata=0xA5.
- Contention in blanking: de=0, both requests held → CPU granted first, PPU the next cycle. rvalids return in that order on consecutive cycles.
- Starvation bound: de=1, ppu_req held continuously, cpu_req held, CPU_MAX_WAIT=4 → exactly 4 PPU grants, then one CPU grant, then the PPU resumes.
- Write-then-read: CPU writes 0x3C to 0x7FFF, then PPU reads 0x7FFF in the next cycle → ppu_rdata=0x3C, no cpu_rvalid for the write.
- Reset mid-flight: accept a PPU read, assert rst_n=0 one cycle later → ppu_rvalid never pulses, pipeline is empty after release.
- Random soak: 10k cycles of random req/de against a scoreboard → every accepted read returns exactly once, in order, with correct data; gnts are never simultaneous.
